flag_buf_fifo: RTL and testbench

Parametrised successor to the single-entry receive flag buffer: holds up to DEPTH words of W bits between the UART receiver and its consumer instead of one. The receiver pushes with set_flag, the consumer pops with clr_flag, and flag reports "data available". Adds full/count status, a sticky overrun flag and a selectable overrun policy, so back-to-back received frames are not lost while the consumer is busy.

---
 rtl/flag_buf_pkg.sv | 12 +
 rtl/flag_buf_fifo_wrap_ctr.sv | 22 ++
 rtl/flag_buf_fifo.sv | 99 +++++++++
 tb/tb_flag_buf_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_buf_pkg.sv
// Shared constants and helpers for the multi-entry receive flag buffer.
package flag_buf_pkg;

  localparam int OVR_DROP      = 0;
  localparam int OVR_OVERWRITE = 1;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/flag_buf_fifo_wrap_ctr.sv
// Modulo-2^WIDTH pointer: advances by one on each enabled edge and wraps naturally.
module wrap_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value_reg <= '0;
    else if (inc)
      value_reg <= value_reg + WIDTH'(1);
  end

  assign value = value_reg;

endmodule

// File: rtl/flag_buf_fifo.sv
// DEPTH-entry receive buffer between a UART receiver and its consumer, with
// first-word fall-through output, occupancy status and a sticky overrun flag.
module flag_buf_fifo
  import flag_buf_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int OVR_MODE = OVR_DROP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       set_flag,
  input  logic [W-1:0]               din,
  input  logic                       clr_flag,
  input  logic                       clr_overrun,
  output logic [W-1:0]               dout,
  output logic                       flag,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit OVERWRITE = (OVR_MODE == OVR_OVERWRITE);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overrun_reg;

  logic is_full;
  logic is_empty;
  logic ovr_event;
  logic write_en;
  logic rd_inc;

  assign is_full  = (count_reg == FULL_CNT);
  assign is_empty = (count_reg == '0);

  // A pop in the same cycle frees a slot, so only an unaccompanied push overruns.
  assign ovr_event = set_flag && is_full && !clr_flag;
  assign write_en  = set_flag && (!is_full || clr_flag || OVERWRITE);
  assign rd_inc    = (clr_flag && !is_empty) || (ovr_event && OVERWRITE);

  wrap_ctr #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (write_en),
    .value (wr_ptr)
  );

  wrap_ctr #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .value (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else if (write_en) begin
      mem_reg[wr_ptr] <= din;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (write_en && !rd_inc)
      count_next = count_reg + CW'(1);
    else if (!write_en && rd_inc)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (ovr_event)
        overrun_reg <= 1'b1;
      else if (clr_overrun)
        overrun_reg <= 1'b0;
    end
  end

  assign dout    = mem_reg[rd_ptr];
  assign flag    = !is_empty;
  assign full    = is_full;
  assign count   = count_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_flag_buf_fifo.sv
// Checks a drop-policy and an overwrite-policy buffer side by side against an
// ordered-list reference model, directed tables and randomized traffic.
module tb_flag_buf_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         set_flag = 1'b0;
  logic [W-1:0] din = '0;
  logic         clr_flag = 1'b0;
  logic         clr_overrun = 1'b0;

  logic [W-1:0] dout_a    [2];
  logic         flag_a    [2];
  logic         full_a    [2];
  logic [2:0]   count_a   [2];
  logic         overrun_a [2];

  int total = 0;
  int bad   = 0;

  // Reference model: stored words in arrival order, index 0 is the oldest.
  int           mcnt [2];
  logic [W-1:0] mdat [2][DEPTH];
  bit           movr [2];

  typedef struct {
    logic         s;
    logic [W-1:0] d;
    logic         c;
    logic         co;
    int           cnt0;
    bit           o0;
    logic [W-1:0] d0;
    int           cnt1;
    bit           o1;
    logic [W-1:0] d1;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  flag_buf_fifo #(.W(W), .DEPTH(DEPTH), .OVR_MODE(0)) dut_drop (
    .clk         (clk),
    .reset       (reset),
    .set_flag    (set_flag),
    .din         (din),
    .clr_flag    (clr_flag),
    .clr_overrun (clr_overrun),
    .dout        (dout_a[0]),
    .flag        (flag_a[0]),
    .full        (full_a[0]),
    .count       (count_a[0]),
    .overrun     (overrun_a[0])
  );

  flag_buf_fifo #(.W(W), .DEPTH(DEPTH), .OVR_MODE(1)) dut_ovw (
    .clk         (clk),
    .reset       (reset),
    .set_flag    (set_flag),
    .din         (din),
    .clr_flag    (clr_flag),
    .clr_overrun (clr_overrun),
    .dout        (dout_a[1]),
    .flag        (flag_a[1]),
    .full        (full_a[1]),
    .count       (count_a[1]),
    .overrun     (overrun_a[1])
  );

  task automatic check(input string name, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h want=%0h", name, m, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      movr[m] = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mdat[m][i] = '0;
    end
  endtask

  task automatic model_pop(input int m);
    for (int i = 0; i < DEPTH - 1; i++)
      mdat[m][i] = mdat[m][i+1];
    mcnt[m]--;
  endtask

  task automatic model_step(input logic s, input logic [W-1:0] d, input logic c,
                            input logic co);
    for (int m = 0; m < 2; m++) begin
      bit ev;
      ev = 1'b0;
      if (c && mcnt[m] > 0)
        model_pop(m);
      if (s) begin
        if (mcnt[m] < DEPTH) begin
          mdat[m][mcnt[m]] = d;
          mcnt[m]++;
        end else begin
          ev = 1'b1;
          if (m == 1) begin
            model_pop(m);
            mdat[m][mcnt[m]] = d;
            mcnt[m]++;
          end
        end
      end
      if (ev)
        movr[m] = 1'b1;
      else if (co)
        movr[m] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    for (int m = 0; m < 2; m++) begin
      check({tag, ".count"}, m, 32'(count_a[m]), 32'(mcnt[m]));
      check({tag, ".flag"}, m, 32'(flag_a[m]), 32'(mcnt[m] > 0));
      check({tag, ".full"}, m, 32'(full_a[m]), 32'(mcnt[m] == DEPTH));
      check({tag, ".overrun"}, m, 32'(overrun_a[m]), 32'(movr[m]));
      if (mcnt[m] > 0)
        check({tag, ".dout"}, m, 32'(dout_a[m]), 32'(mdat[m][0]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check({tag, ".count"}, m, 32'(count_a[m]), 32'd0);
      check({tag, ".flag"}, m, 32'(flag_a[m]), 32'd0);
      check({tag, ".full"}, m, 32'(full_a[m]), 32'd0);
      check({tag, ".overrun"}, m, 32'(overrun_a[m]), 32'd0);
      check({tag, ".dout"}, m, 32'(dout_a[m]), 32'd0);
    end
  endtask

  // Called at a falling edge: drive, clock, update model, sample at next falling edge.
  task automatic step(input string tag, input logic s, input logic [W-1:0] d,
                      input logic c, input logic co);
    set_flag = s;
    din = d;
    clr_flag = c;
    clr_overrun = co;
    @(posedge clk);
    model_step(s, d, c, co);
    @(negedge clk);
    set_flag = 1'b0;
    clr_flag = 1'b0;
    clr_overrun = 1'b0;
    $display("%s set=%0b din=%02h clr=%0b clro=%0b -> cnt=%0d/%0d ovr=%0b/%0b dout=%02h/%02h",
             tag, s, d, c, co, count_a[0], count_a[1], overrun_a[0], overrun_a[1],
             dout_a[0], dout_a[1]);
    check_model(tag);
  endtask

  task automatic row2(input logic s, input logic [W-1:0] d, input logic c, input logic co,
                      input int c0, input bit o0, input logic [W-1:0] d0,
                      input int c1, input bit o1, input logic [W-1:0] d1);
    vec_t v;
    v = '{s: s, d: d, c: c, co: co, cnt0: c0, o0: o0, d0: d0, cnt1: c1, o1: o1, d1: d1};
    tbl.push_back(v);
  endtask

  task automatic row(input logic s, input logic [W-1:0] d, input logic c, input logic co,
                     input int cn, input bit o, input logic [W-1:0] dd);
    row2(s, d, c, co, cn, o, dd, cn, o, dd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();

    // Directed vectors: push/pop, fill/drain, both overrun policies, push+pop corners.
    row(1, 8'hA1, 0, 0, 1, 0, 8'hA1);
    row(1, 8'hB2, 0, 0, 2, 0, 8'hA1);
    row(0, 8'h00, 1, 0, 1, 0, 8'hB2);
    row(0, 8'h00, 1, 0, 0, 0, 8'h00);
    row(1, 8'h01, 0, 0, 1, 0, 8'h01);
    row(1, 8'h02, 0, 0, 2, 0, 8'h01);
    row(1, 8'h03, 0, 0, 3, 0, 8'h01);
    row(1, 8'h04, 0, 0, 4, 0, 8'h01);
    row(0, 8'h00, 1, 0, 3, 0, 8'h02);
    row(0, 8'h00, 1, 0, 2, 0, 8'h03);
    row(0, 8'h00, 1, 0, 1, 0, 8'h04);
    row(0, 8'h00, 1, 0, 0, 0, 8'h00);
    row(0, 8'h00, 1, 0, 0, 0, 8'h00);
    row(1, 8'h01, 0, 0, 1, 0, 8'h01);
    row(1, 8'h02, 0, 0, 2, 0, 8'h01);
    row(1, 8'h03, 0, 0, 3, 0, 8'h01);
    row(1, 8'h04, 0, 0, 4, 0, 8'h01);
    row2(1, 8'h55, 0, 0, 4, 1, 8'h01, 4, 1, 8'h02);
    row2(0, 8'h00, 0, 1, 4, 0, 8'h01, 4, 0, 8'h02);
    row2(0, 8'h00, 1, 0, 3, 0, 8'h02, 3, 0, 8'h03);
    row2(0, 8'h00, 1, 0, 2, 0, 8'h03, 2, 0, 8'h04);
    row2(0, 8'h00, 1, 0, 1, 0, 8'h04, 1, 0, 8'h55);
    row(0, 8'h00, 1, 0, 0, 0, 8'h00);
    row(1, 8'h77, 1, 0, 1, 0, 8'h77);
    row(1, 8'h88, 0, 0, 2, 0, 8'h77);
    row(1, 8'h77, 1, 0, 2, 0, 8'h88);
    row(1, 8'h99, 0, 0, 3, 0, 8'h88);
    row(1, 8'hAA, 0, 0, 4, 0, 8'h88);
    row(1, 8'h77, 1, 0, 4, 0, 8'h77);

    // Reset state, checked while reset is held low.
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].co);
      check("tbl.count", 0, 32'(count_a[0]), 32'(tbl[i].cnt0));
      check("tbl.count", 1, 32'(count_a[1]), 32'(tbl[i].cnt1));
      check("tbl.overrun", 0, 32'(overrun_a[0]), 32'(tbl[i].o0));
      check("tbl.overrun", 1, 32'(overrun_a[1]), 32'(tbl[i].o1));
      if (tbl[i].cnt0 > 0)
        check("tbl.dout", 0, 32'(dout_a[0]), 32'(tbl[i].d0));
      if (tbl[i].cnt1 > 0)
        check("tbl.dout", 1, 32'(dout_a[1]), 32'(tbl[i].d1));
    end

    // Sustained push+pop at full: pointers wrap several times.
    for (int i = 0; i < 10; i++)
      step($sformatf("wrap%0d", i), 1'b1, W'($urandom_range(255)), 1'b1, 1'b0);

    // Overrun event and clr_overrun in the same cycle keep overrun set.
    step("ovr_clr", 1'b1, 8'hC3, 1'b0, 1'b1);
    check("ovr_clr.same", 0, 32'(overrun_a[0]), 32'd1);
    check("ovr_clr.same", 1, 32'(overrun_a[1]), 32'd1);

    // Randomized traffic, biased toward pushes so full/overrun are reached.
    for (int i = 0; i < 400; i++) begin
      logic s, c, co;
      s  = ($urandom_range(99) < 60);
      c  = ($urandom_range(99) < ((i % 100) < 50 ? 30 : 70));
      co = ($urandom_range(99) < 10);
      step($sformatf("rnd%0d", i), s, W'($urandom_range(255)), c, co);
    end

    // Asynchronous reset mid-push with count=3 and overrun set.
    do_reset();
    for (int i = 1; i <= 4; i++)
      step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    step("ovr", 1'b1, 8'h55, 1'b0, 1'b0);
    step("pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset.count", 0, 32'(count_a[0]), 32'd3);
    check("pre_reset.overrun", 1, 32'(overrun_a[1]), 32'd1);
    set_flag = 1'b1;
    din = 8'h5A;
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk);
    set_flag = 1'b0;
    reset = 1'b1;
    model_clear();
    step("post_reset", 1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_reset.dout", 0, 32'(dout_a[0]), 32'h3C);
    check("post_reset.count", 1, 32'(count_a[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
